// File: rtl/cpu_mul_sequencer.sv
// Two-stage sequencer around an external registered 32x32 signed multiplier: S1 holds op/tag/correction
// while the product settles, the output register adds the unsigned correction. Latency 2, 1 op/cycle.
module cpu_mul_sequencer #(
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [31:0]          in_a,
  input  logic [31:0]          in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic [31:0]          mul_din0,
  output logic [31:0]          mul_din1,
  output logic                 mul_ce,
  input  logic [63:0]          mul_dout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 busy
);

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  logic                 s1_valid;
  op_e                  s1_op;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic [31:0]          s1_corr;
  logic [31:0]          corr_next;
  logic [31:0]          result_next;
  logic                 s1_advance;
  logic                 accept;

  assign s1_advance = s1_valid & (~out_valid | out_ready);
  assign in_ready   = reset & ~flush & (~s1_valid | s1_advance);
  assign accept     = in_valid & in_ready;
  assign mul_din0   = in_a;
  assign mul_din1   = in_b;
  // The multiplier only clocks on accept, so its output keeps S1's product until S1 moves on.
  assign mul_ce     = accept;
  assign busy       = s1_valid | out_valid;

  // Turns the signed x signed high word into the MULHSU / MULHU high word.
  always_comb begin
    corr_next = '0;
    case (op_e'(in_op))
      OP_MULHSU: corr_next = in_b[31] ? in_a : 32'd0;
      OP_MULHU:  corr_next = (in_b[31] ? in_a : 32'd0) + (in_a[31] ? in_b : 32'd0);
      default:   corr_next = '0;
    endcase
  end

  assign result_next = (s1_op == OP_MUL) ? mul_dout[31:0] : (mul_dout[63:32] + s1_corr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid   <= 1'b0;
      s1_op      <= OP_MUL;
      s1_tag     <= '0;
      s1_corr    <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_op    <= op_e'(in_op);
        s1_tag   <= in_tag;
        s1_corr  <= corr_next;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end

      if (s1_advance) begin
        out_valid  <= 1'b1;
        out_result <= result_next;
        out_tag    <= s1_tag;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
